// File: rtl/dma_mem_onchip_arbiter_pkg.sv
// Shared types and sizes for the on-chip DMA memory and its arbiters.
// Package name is dma_mem_pkg so later shared-resource blocks can import it unchanged.
package dma_mem_pkg;
    localparam int MEM_AW            = 18;
    localparam int MEM_DW            = 16;
    localparam int MEM_BEW           = 2;
    localparam int MEM_DEPTH_DEFAULT = 196608;

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} arb_state_t;
    typedef logic [0:0] port_id_t;

    typedef struct packed {
        logic [MEM_AW-1:0]  address;
        logic [MEM_BEW-1:0] byteenable;
        logic               write;
        logic [MEM_DW-1:0]  writedata;
    } arb_req_t;
endpackage

// File: rtl/dma_mem_onchip_arbiter_if.sv
// One Avalon-MM master port as seen by the arbiter (slave modport) or a master (master modport).
interface dma_mem_onchip_arbiter_if;
    import dma_mem_pkg::*;
    logic [MEM_AW-1:0]  address;
    logic [MEM_BEW-1:0] byteenable;
    logic               read;
    logic               write;
    logic [MEM_DW-1:0]  writedata;
    logic               waitrequest;
    logic [MEM_DW-1:0]  readdata;
    logic               readdatavalid;

    modport master (output address, byteenable, read, write, writedata,
                    input  waitrequest, readdata, readdatavalid);
    modport slave  (input  address, byteenable, read, write, writedata,
                    output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/dma_mem_rr_arb2.sv
// Two-requester round-robin grant; last_grant advances only when the caller reports an accept.
module dma_mem_rr_arb2
    import dma_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o,
    output port_id_t   gnt_id_o
);
    port_id_t last_grant_q;

    always_ff @(posedge clk) begin
        if (reset)      last_grant_q <= 1'b1;
        else if (adv_i) last_grant_q <= gnt_id_o;
    end

    always_comb begin
        gnt_id_o = ~last_grant_q;
        if (req_i == 2'b01)      gnt_id_o = 1'b0;
        else if (req_i == 2'b10) gnt_id_o = 1'b1;
        gnt_o[0] = req_i[0] & (gnt_id_o == 1'b0);
        gnt_o[1] = req_i[1] & (gnt_id_o == 1'b1);
    end
endmodule

// File: rtl/dma_mem_onchip_arbiter.sv
// Round-robin arbiter in front of the single-port on-chip RAM (DMA = port 0, host = port 1).
// Optional perf counters under `DMA_MEM_ARB_PERF_EN.
module dma_mem_onchip_arbiter
    import dma_mem_pkg::*;
#(
    parameter int              MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter logic [MEM_DW-1:0] OOR_RDATA = 16'hDEAD
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req_i,
    dma_mem_onchip_arbiter_if.slave m0_if,
    dma_mem_onchip_arbiter_if.slave m1_if,
    output logic [MEM_AW-1:0]   mem_address_o,
    output logic [MEM_BEW-1:0]  mem_byteenable_o,
    output logic                mem_chipselect_o,
    output logic                mem_write_o,
    output logic [MEM_DW-1:0]   mem_writedata_o,
    output logic                mem_clken_o,
    input  logic [MEM_DW-1:0]   mem_readdata_i
`ifdef DMA_MEM_ARB_PERF_EN
    ,
    input  logic                perf_clr_i,
    output logic [31:0]         perf_grant0_o,
    output logic [31:0]         perf_grant1_o,
    output logic [31:0]         perf_stall0_o,
    output logic [31:0]         perf_stall1_o
`endif
);
    localparam logic [MEM_AW:0] DEPTH_W = (MEM_AW+1)'(MEM_DEPTH);

    arb_state_t          state_q, state_d;
    arb_req_t [1:0]      p_req;
    arb_req_t            sel;
    logic     [1:0]      req, gnt, wait_p, rdv;
    port_id_t            gnt_id, rd_port_q;
    logic                acc, in_rng, rd_pend_q, rd_oor_q;
    logic [MEM_DW-1:0]   rdata;

    assign req      = {m1_if.read | m1_if.write, m0_if.read | m0_if.write};
    assign p_req[0] = '{m0_if.address, m0_if.byteenable, m0_if.write, m0_if.writedata};
    assign p_req[1] = '{m1_if.address, m1_if.byteenable, m1_if.write, m1_if.writedata};

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (reset_req_i)  state_d = HOLD;
            HOLD:    if (!reset_req_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Gating on reset_req directly keeps the rising cycle frozen and lets the
    // first cycle after deassertion grant, before state_q has returned to RUN.
    assign mem_clken_o = ~reset_req_i & ((state_q == RUN) | ~reset_req_i);
    assign acc         = mem_clken_o & ~reset & (|req);

    dma_mem_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .adv_i    (acc),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign sel    = p_req[gnt_id];
    assign in_rng = {1'b0, sel.address} < DEPTH_W;
    assign wait_p = ~({2{acc}} & gnt);

    always_comb begin
        mem_address_o    = sel.address;
        mem_byteenable_o = sel.byteenable;
        mem_writedata_o  = sel.writedata;
        mem_chipselect_o = acc;
        mem_write_o      = acc & sel.write & in_rng;
    end

    // Read+write together counts as a write, so no return beat is scheduled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            rd_pend_q <= acc & ~sel.write;
            if (acc) begin
                rd_port_q <= gnt_id;
                rd_oor_q  <= ~in_rng;
            end
        end
    end

    assign rdv[0] = rd_pend_q & ~reset & (rd_port_q == 1'b0);
    assign rdv[1] = rd_pend_q & ~reset & (rd_port_q == 1'b1);
    assign rdata  = rd_oor_q ? OOR_RDATA : mem_readdata_i;

    assign m0_if.waitrequest   = wait_p[0];
    assign m1_if.waitrequest   = wait_p[1];
    assign m0_if.readdatavalid = rdv[0];
    assign m1_if.readdatavalid = rdv[1];
    assign m0_if.readdata      = rdv[0] ? rdata : '0;
    assign m1_if.readdata      = rdv[1] ? rdata : '0;

`ifdef DMA_MEM_ARB_PERF_EN
    logic [3:0]       ev;
    logic [3:0][31:0] perf_q;

    assign ev = {req[1] & wait_p[1], req[0] & wait_p[0], acc & gnt[1], acc & gnt[0]};

    for (genvar i = 0; i < 4; i++) begin : g_perf
        always_ff @(posedge clk) begin
            if (reset || perf_clr_i)               perf_q[i] <= '0;
            else if (ev[i] && (perf_q[i] != '1))   perf_q[i] <= perf_q[i] + 32'd1;
        end
    end

    assign perf_grant0_o = perf_q[0];
    assign perf_grant1_o = perf_q[1];
    assign perf_stall0_o = perf_q[2];
    assign perf_stall1_o = perf_q[3];
`endif
endmodule

// File: tb/tb_dma_mem_onchip_arbiter.sv
// Directed bench for dma_mem_onchip_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dma_mem_onchip_arbiter;
    import dma_mem_pkg::*;

    logic clk = 1'b0;
    logic reset, reset_req;
    logic [MEM_AW-1:0]  mem_address;
    logic [MEM_BEW-1:0] mem_byteenable;
    logic               mem_chipselect, mem_write, mem_clken;
    logic [MEM_DW-1:0]  mem_writedata, mem_readdata;
`ifdef DMA_MEM_ARB_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_grant0, perf_grant1, perf_stall0, perf_stall1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dma_mem_onchip_arbiter_if m0();
    dma_mem_onchip_arbiter_if m1();

    dma_mem_onchip_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .reset_req_i      (reset_req),
        .m0_if            (m0),
        .m1_if            (m1),
        .mem_address_o    (mem_address),
        .mem_byteenable_o (mem_byteenable),
        .mem_chipselect_o (mem_chipselect),
        .mem_write_o      (mem_write),
        .mem_writedata_o  (mem_writedata),
        .mem_clken_o      (mem_clken),
        .mem_readdata_i   (mem_readdata)
`ifdef DMA_MEM_ARB_PERF_EN
        ,
        .perf_clr_i       (perf_clr),
        .perf_grant0_o    (perf_grant0),
        .perf_grant1_o    (perf_grant1),
        .perf_stall0_o    (perf_stall0),
        .perf_stall1_o    (perf_stall1)
`endif
    );

    always #5 clk = ~clk;

    // RAM: address register captured under clken, combinational read from it.
    logic [15:0] ram [0:196607];
    logic [17:0] ram_a_q;
    initial begin
        ram_a_q <= '0;
        for (int i = 0; i < 196608; i++) ram[i] <= '0;
    end
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            ram_a_q <= mem_address;
            if (mem_write && mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_write && mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
        end
    end
    assign mem_readdata = (ram_a_q < 18'd196608) ? ram[ram_a_q] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic rd, input logic wr,
                         input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        if (p == 0) begin
            m0.read = rd; m0.write = wr; m0.address = a; m0.writedata = d; m0.byteenable = be;
        end else begin
            m1.read = rd; m1.write = wr; m1.address = a; m1.writedata = d; m1.byteenable = be;
        end
    endtask

    initial begin
        reset = 1'b1; reset_req = 1'b0;
`ifdef DMA_MEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        drive(0, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        drive(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        step; step;
        @(negedge clk);
        check("rst_wait0", m0.waitrequest, 1);
        check("rst_wait1", m1.waitrequest, 1);
        check("rst_rdv0", m0.readdatavalid, 0);
        check("rst_rdv1", m1.readdatavalid, 0);
        check("rst_rdata0", m0.readdata, 0);
        check("rst_cs", mem_chipselect, 0);
        check("rst_mwr", mem_write, 0);

        // write then read back on the other port
        step; reset = 1'b0;
        drive(0, 1'b0, 1'b1, 18'h00010, 16'h1234, 2'b11);
        @(negedge clk);
        check("wr_wait0", m0.waitrequest, 0);
        check("wr_mwr", mem_write, 1);
        check("wr_maddr", mem_address, 18'h00010);
        step;
        drive(0, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        drive(1, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        @(negedge clk);
        check("rd_wait1", m1.waitrequest, 0);
        check("rd_mwr", mem_write, 0);
        check("rd_rdv1_early", m1.readdatavalid, 0);
        step;
        drive(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        @(negedge clk);
        check("rd_rdv1", m1.readdatavalid, 1);
        check("rd_data1", m1.readdata, 16'h1234);
        check("rd_rdv0", m0.readdatavalid, 0);

        // contention: last grant was 1, so order is 0,1,0,1...
        step;
        drive(0, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        drive(1, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr_wait0_%0d", i), m0.waitrequest, (i % 2 == 1));
            check($sformatf("rr_wait1_%0d", i), m1.waitrequest, (i % 2 == 0));
            if (i > 0) begin
                check($sformatf("rr_rdv0_%0d", i), m0.readdatavalid, (i % 2 == 1));
                check($sformatf("rr_rdv1_%0d", i), m1.readdatavalid, (i % 2 == 0));
                check($sformatf("rr_data_%0d", i), m0.readdata | m1.readdata, 16'h1234);
            end
            step;
        end
        drive(0, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        drive(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        @(negedge clk);
        check("rr_tail_rdv1", m1.readdatavalid, 1);
        check("rr_tail_rdv0", m0.readdatavalid, 0);

        // byte lane write at last word, then out-of-range read/write
        step;
        drive(0, 1'b0, 1'b1, 18'h2FFFF, 16'hBEEF, 2'b01);
        @(negedge clk);
        check("be_wait0", m0.waitrequest, 0);
        check("be_mwr", mem_write, 1);
        step;
        drive(0, 1'b1, 1'b0, 18'h2FFFF, 16'h0, 2'b11);
        @(negedge clk);
        check("be_rd_wait0", m0.waitrequest, 0);
        step;
        drive(0, 1'b1, 1'b0, 18'h30000, 16'h0, 2'b11);
        @(negedge clk);
        check("be_rdv0", m0.readdatavalid, 1);
        check("be_data0", m0.readdata, 16'h00EF);
        check("oor_rd_wait0", m0.waitrequest, 0);
        step;
        drive(0, 1'b0, 1'b1, 18'h30000, 16'h1111, 2'b11);
        @(negedge clk);
        check("oor_rdv0", m0.readdatavalid, 1);
        check("oor_data0", m0.readdata, 16'hDEAD);
        check("oor_wr_wait0", m0.waitrequest, 0);
        check("oor_wr_cs", mem_chipselect, 1);
        check("oor_wr_mwr", mem_write, 0);

        // read accepted just before reset_req rises still returns
        step;
        drive(0, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        @(negedge clk);
        check("hold_pre_wait0", m0.waitrequest, 0);
        step;
        reset_req = 1'b1;
        drive(1, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold_wait0_%0d", k), m0.waitrequest, 1);
            check($sformatf("hold_wait1_%0d", k), m1.waitrequest, 1);
            check($sformatf("hold_clken_%0d", k), mem_clken, 0);
            check($sformatf("hold_cs_%0d", k), mem_chipselect, 0);
            check($sformatf("hold_rdv0_%0d", k), m0.readdatavalid, (k == 0));
            if (k == 0) check("hold_data0", m0.readdata, 16'h1234);
            step;
        end
        reset_req = 1'b0;
        @(negedge clk);
        check("resume_clken", mem_clken, 1);
        check("resume_wait1", m1.waitrequest, 0);
        check("resume_wait0", m0.waitrequest, 1);

        // reset right after a read accept
        step;
        drive(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        @(negedge clk);
        check("prerst_wait0", m0.waitrequest, 0);
        step;
        reset = 1'b1;
        drive(1, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        @(negedge clk);
        check("rst2_rdv0", m0.readdatavalid, 0);
        check("rst2_rdata0", m0.readdata, 0);
        check("rst2_wait0", m0.waitrequest, 1);
        check("rst2_wait1", m1.waitrequest, 1);
        check("rst2_cs", mem_chipselect, 0);
        step;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_wait0", m0.waitrequest, 0);
        check("post_rst_wait1", m1.waitrequest, 1);
        step;
        drive(0, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        drive(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);

`ifdef DMA_MEM_ARB_PERF_EN
        perf_clr = 1'b1;
        step;
        perf_clr = 1'b0;
        drive(0, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        drive(1, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
        for (int c = 0; c < 10; c++) step;
        drive(0, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        drive(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
        @(negedge clk);
        check("perf_g0", perf_grant0, 5);
        check("perf_g1", perf_grant1, 5);
        check("perf_s0", perf_stall0, 5);
        check("perf_s1", perf_stall1, 5);
        step;
        perf_clr = 1'b1;
        step;
        perf_clr = 1'b0;
        @(negedge clk);
        check("perf_clr", perf_grant0 | perf_grant1 | perf_stall0 | perf_stall1, 0);
`endif

        step;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
